// File: rtl/dff_logic_pipe.sv
// Elastic register pipeline of DEPTH stages with valid/ready handshake, bubble collapse,
// synchronous flush and an occupancy counter. q is driven straight from the last stage.
module dff_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         c,
  input  logic                         r,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0]             adv, load;
  logic [DEPTH-1:0][WIDTH-1:0]  data_q, data_d;
  logic [CW-1:0]                count_q, count_d;
  logic                         in_xfer, out_xfer;

  // Walk from the output side: a stage advances when it is valid and everything
  // downstream of it can make room (empty or itself advancing).
  always_comb begin
    logic nf;
    nf       = out_ready;
    adv      = '0;
    load     = '0;
    vld_d    = vld_q;
    data_d   = data_q;
    in_ready = 1'b0;
    in_xfer  = 1'b0;
    out_xfer = 1'b0;
    count_d  = count_q;

    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = vld_q[i] & nf;
      nf     = ~vld_q[i] | nf;
    end

    in_ready = nf & ~flush;
    in_xfer  = in_valid & in_ready;
    out_xfer = vld_q[DEPTH-1] & out_ready;

    load[0] = in_xfer;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = adv[i-1];
    end

    for (int i = 0; i < DEPTH; i++) begin
      vld_d[i] = (vld_q[i] & ~adv[i]) | load[i];
    end

    if (load[0]) data_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      if (load[i]) data_d[i] = data_q[i-1];
    end

    case ({in_xfer, out_xfer})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State register; flush drops valid bits and occupancy but leaves stale data in place.
  always_ff @(posedge c) begin
    if (r) begin
      vld_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q <= data_d;
      if (flush) begin
        vld_q   <= '0;
        count_q <= '0;
      end else begin
        vld_q   <= vld_d;
        count_q <= count_d;
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign q         = data_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_dff_logic_pipe.sv
// Directed-vector bench for dff_logic_pipe: DEPTH=4 main instance plus a DEPTH=1 build.
module tb_dff_logic_pipe;

  logic       c = 1'b0;
  logic       r, flush, in_valid, out_ready;
  logic [7:0] d, q;
  logic       in_ready, out_valid;
  logic [2:0] count;

  logic       flush1, in_valid1, out_ready1, in_ready1, out_valid1;
  logic [7:0] d1, q1;
  logic [0:0] count1;

  int nvec = 0;
  int nmis = 0;

  dff_logic_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .c(c), .r(r), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .out_valid(out_valid), .out_ready(out_ready), .q(q), .count(count)
  );

  dff_logic_pipe #(.WIDTH(8), .DEPTH(1)) dut1 (
    .c(c), .r(r), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .d(d1), .out_valid(out_valid1), .out_ready(out_ready1), .q(q1), .count(count1)
  );

  initial forever #5 c = ~c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge c);
    #1;
  endtask

  initial begin
    r = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = '0;
    flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; d1 = '0;

    // reset state
    tick; tick; #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_count", 32'(count), 0);
    r = 1'b0;
    tick; #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // single word, latency DEPTH
    in_valid = 1'b1; d = 8'h11; out_ready = 1'b1; #1;
    chk("lat_in_ready", 32'(in_ready), 1);
    for (int k = 1; k <= 5; k++) begin
      tick; in_valid = 1'b0; #1;
      chk("lat_count", 32'(count), (k <= 4) ? 1 : 0);
      chk("lat_out_valid", 32'(out_valid), (k == 4) ? 1 : 0);
      if (k == 4) chk("lat_q", 32'(q), 32'h11);
    end
    tick;

    // back-to-back stream 0x01..0x0A
    for (int cy = 0; cy < 15; cy++) begin
      in_valid = (cy < 10); d = 8'(cy + 1); #1;
      if (cy < 10) chk("strm_in_ready", 32'(in_ready), 1);
      chk("strm_out_valid", 32'(out_valid), (cy >= 4 && cy <= 13) ? 1 : 0);
      if (cy >= 4 && cy <= 13) chk("strm_q", 32'(q), 32'(cy - 3));
      tick;
    end

    // backpressure: fill, stall, then simultaneous in/out at full
    out_ready = 1'b0;
    for (int cy = 0; cy < 4; cy++) begin
      in_valid = 1'b1; d = 8'(8'h21 + cy); #1;
      chk("bp_fill_ready", 32'(in_ready), 1);
      tick;
    end
    for (int cy = 4; cy < 6; cy++) begin
      in_valid = 1'b1; d = 8'h25; #1;
      chk("bp_full_ready", 32'(in_ready), 0);
      chk("bp_full_count", 32'(count), 4);
      chk("bp_stall_valid", 32'(out_valid), 1);
      chk("bp_stall_q", 32'(q), 32'h21);
      tick;
    end
    out_ready = 1'b1; d = 8'h25; #1;
    chk("bp_sim_ready", 32'(in_ready), 1);
    chk("bp_sim_q", 32'(q), 32'h21);
    tick;
    d = 8'h26; #1;
    chk("bp_sim_ready2", 32'(in_ready), 1);
    chk("bp_sim_count", 32'(count), 4);
    chk("bp_order_q", 32'(q), 32'h22);
    tick;
    for (int cy = 8; cy < 12; cy++) begin
      in_valid = 1'b0; #1;
      chk("bp_drain_valid", 32'(out_valid), 1);
      chk("bp_drain_q", 32'(q), 32'(8'h20 + cy - 5));
      chk("bp_drain_count", 32'(count), 32'(12 - cy));
      tick;
    end
    #1;
    chk("bp_empty_valid", 32'(out_valid), 0);
    chk("bp_empty_count", 32'(count), 0);
    tick;

    // flush with three words held
    out_ready = 1'b0;
    for (int cy = 0; cy < 3; cy++) begin
      in_valid = 1'b1; d = 8'(8'h31 + cy); #1;
      tick;
    end
    flush = 1'b1; in_valid = 1'b1; d = 8'hEE; #1;
    chk("fl_in_ready", 32'(in_ready), 0);
    chk("fl_count_pre", 32'(count), 3);
    tick;
    flush = 1'b0; in_valid = 1'b1; d = 8'h44; out_ready = 1'b1; #1;
    chk("fl_count", 32'(count), 0);
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_in_ready_after", 32'(in_ready), 1);
    tick;
    for (int cy = 5; cy <= 9; cy++) begin
      in_valid = 1'b0; #1;
      chk("fl_new_valid", 32'(out_valid), (cy == 8) ? 1 : 0);
      if (cy == 8) chk("fl_new_q", 32'(q), 32'h44);
      tick;
    end

    // reset mid-stream with two words stored
    out_ready = 1'b0;
    for (int cy = 0; cy < 2; cy++) begin
      in_valid = 1'b1; d = 8'(8'h51 + cy); #1;
      tick;
    end
    in_valid = 1'b0; #1;
    chk("mr_count_pre", 32'(count), 2);
    r = 1'b1;
    tick;
    r = 1'b0; #1;
    chk("mr_count", 32'(count), 0);
    chk("mr_q", 32'(q), 0);
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    tick;
    for (int cy = 0; cy < 5; cy++) begin
      #1;
      chk("mr_no_old_word", 32'(out_valid), 0);
      tick;
    end

    // DEPTH=1 build: latency of one cycle
    in_valid1 = 1'b1; d1 = 8'h11; out_ready1 = 1'b1; #1;
    chk("d1_in_ready", 32'(in_ready1), 1);
    tick;
    in_valid1 = 1'b0; #1;
    chk("d1_out_valid", 32'(out_valid1), 1);
    chk("d1_q", 32'(q1), 32'h11);
    chk("d1_count", 32'(count1), 1);
    tick; #1;
    chk("d1_out_valid_after", 32'(out_valid1), 0);
    chk("d1_count_after", 32'(count1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
